// File: rtl/lifo_access_arbiter.sv
// Round-robin arbiter that shares one synchronous LIFO among NUM_REQ push/pop clients.
// Optional statistics counters are enabled with `define LIFO_ARB_STATS_EN.
module lifo_access_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    op,
  input  logic [NUM_REQ*DW-1:0] wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    err,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  output logic [DW-1:0]         lifo_din,
  output logic                  lifo_wr_en,
  output logic                  lifo_rd_en,
  input  logic [DW-1:0]         lifo_dout,
  input  logic                  lifo_empty,
  input  logic                  lifo_full
`ifdef LIFO_ARB_STATS_EN
  ,
  output logic [15:0]           stat_push,
  output logic [15:0]           stat_pop,
  output logic [15:0]           stat_rej
`endif
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t               r_state;
  logic [PW-1:0]        r_rr_ptr;
  logic [PW-1:0]        r_win;
  logic                 r_op;
  logic [DW-1:0]        r_wdata;
  logic [DW-1:0]        r_rdata;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_rvalid;

  logic [PW-1:0]        w_pick;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic                 w_issue_push;
  logic                 w_issue_pop;
  logic                 w_reject;

  function automatic logic [NUM_REQ-1:0] f_onehot(input logic [PW-1:0] idx);
    f_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Scan downwards so the requester closest after ptr is the last (winning) assignment.
  function automatic logic [PW-1:0] f_pick(input logic [NUM_REQ-1:0] req_v,
                                           input logic [PW-1:0]      ptr);
    logic [PW-1:0] pick;
    int            idx;
    pick = ptr;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req_v[idx]) begin
        pick = PW'(idx);
      end
    end
    return pick;
  endfunction

  // Flags are judged only in ISSUE so a write landing just before still counts.
  assign w_pick       = f_pick(req, r_rr_ptr);
  assign w_win_oh     = f_onehot(r_win);
  assign w_issue_push = (r_state == S_ISSUE) && !r_op && !lifo_full;
  assign w_issue_pop  = (r_state == S_ISSUE) &&  r_op && !lifo_empty;
  assign w_reject     = (r_state == S_ISSUE) && !w_issue_push && !w_issue_pop;

  assign gnt        = r_gnt;
  assign err        = w_reject ? w_win_oh : {NUM_REQ{1'b0}};
  assign rvalid     = r_rvalid;
  assign rdata      = r_rdata;
  assign lifo_din   = r_wdata;
  assign lifo_wr_en = w_issue_push;
  assign lifo_rd_en = w_issue_pop;

  // Transaction sequencer: latch winner, issue one strobe, capture pop data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= PW'(NUM_REQ - 1);
      r_win    <= {PW{1'b0}};
      r_op     <= 1'b0;
      r_wdata  <= {DW{1'b0}};
      r_rdata  <= {DW{1'b0}};
      r_gnt    <= {NUM_REQ{1'b0}};
      r_rvalid <= {NUM_REQ{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rvalid <= {NUM_REQ{1'b0}};
          if (|req) begin
            r_win   <= w_pick;
            r_op    <= op[w_pick];
            r_wdata <= wdata[w_pick*DW +: DW];
            r_gnt   <= f_onehot(w_pick);
            r_state <= S_ISSUE;
          end else begin
            r_gnt   <= {NUM_REQ{1'b0}};
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_gnt    <= {NUM_REQ{1'b0}};
          r_rvalid <= {NUM_REQ{1'b0}};
          r_rr_ptr <= r_win;
          r_state  <= w_issue_pop ? S_CAPTURE : S_IDLE;
        end
        S_CAPTURE: begin
          r_gnt    <= {NUM_REQ{1'b0}};
          r_rdata  <= lifo_dout;
          r_rvalid <= w_win_oh;
          r_state  <= S_IDLE;
        end
        default: begin
          r_gnt    <= {NUM_REQ{1'b0}};
          r_rvalid <= {NUM_REQ{1'b0}};
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LIFO_ARB_STATS_EN
  logic [15:0] r_stat_push;
  logic [15:0] r_stat_pop;
  logic [15:0] r_stat_rej;

  // Saturating event counters; a pop counts once its data is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_push <= 16'd0;
      r_stat_pop  <= 16'd0;
      r_stat_rej  <= 16'd0;
    end else begin
      if (w_issue_push && (r_stat_push != 16'hFFFF)) begin
        r_stat_push <= r_stat_push + 16'd1;
      end
      if ((r_state == S_CAPTURE) && (r_stat_pop != 16'hFFFF)) begin
        r_stat_pop <= r_stat_pop + 16'd1;
      end
      if (w_reject && (r_stat_rej != 16'hFFFF)) begin
        r_stat_rej <= r_stat_rej + 16'd1;
      end
    end
  end

  assign stat_push = r_stat_push;
  assign stat_pop  = r_stat_pop;
  assign stat_rej  = r_stat_rej;
`endif

endmodule

// File: tb/tb_lifo_access_arbiter.sv
// Directed bench for lifo_access_arbiter with a 4-deep behavioural LIFO and a pop-data scoreboard.
module tb_lifo_access_arbiter;

  localparam int NR    = 2;
  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req = '0;
  logic [NR-1:0]   op = '0;
  logic [NR*DW-1:0] wdata = '0;
  logic [NR-1:0]   gnt, err, rvalid;
  logic [DW-1:0]   rdata, lifo_din, lifo_dout;
  logic            lifo_wr_en, lifo_rd_en, lifo_empty, lifo_full;
`ifdef LIFO_ARB_STATS_EN
  logic [15:0]     stat_push, stat_pop, stat_rej;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_push = 0, exp_pop = 0, exp_rej = 0;
  logic [DW-1:0] ref_stack[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] last_rdata;

  always #5 clk = ~clk;

  lifo_access_arbiter #(.NUM_REQ(NR), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata),
    .gnt(gnt), .err(err), .rvalid(rvalid), .rdata(rdata),
    .lifo_din(lifo_din), .lifo_wr_en(lifo_wr_en), .lifo_rd_en(lifo_rd_en),
    .lifo_dout(lifo_dout), .lifo_empty(lifo_empty), .lifo_full(lifo_full)
`ifdef LIFO_ARB_STATS_EN
    , .stat_push(stat_push), .stat_pop(stat_pop), .stat_rej(stat_rej)
`endif
  );

  // Behavioural LIFO partner: data appears the cycle after rd_en.
  logic [DW-1:0] mem [DEPTH];
  int            cnt;
  assign lifo_empty = (cnt == 0);
  assign lifo_full  = (cnt == DEPTH);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= 0;
      lifo_dout <= '0;
    end else if (lifo_wr_en && cnt < DEPTH) begin
      mem[cnt] <= lifo_din;
      cnt      <= cnt + 1;
    end else if (lifo_rd_en && cnt > 0) begin
      lifo_dout <= mem[cnt-1];
      cnt       <= cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output logic [NR-1:0] g);
    g = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g = gnt;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    ref_stack.delete();
    sb.delete();
    exp_push = 0;
    exp_pop  = 0;
    exp_rej  = 0;
  endtask

  task automatic check_stats();
`ifdef LIFO_ARB_STATS_EN
    check("stat_push", stat_push, 16'(exp_push));
    check("stat_pop",  stat_pop,  16'(exp_pop));
    check("stat_rej",  stat_rej,  16'(exp_rej));
`endif
  endtask

  // One complete client transaction, checked from grant through pop data.
  task automatic txn(input int c, input logic o, input logic [DW-1:0] d, input logic exp_err);
    logic [NR-1:0] g, oh, seen;
    oh = NR'(1) << c;
    @(negedge clk);
    req[c] = 1'b1;
    op[c]  = o;
    wdata[c*DW +: DW] = d;
    wait_gnt(g);
    check("gnt", 16'(g), 16'(oh));
    check("err", 16'(err), exp_err ? 16'(oh) : 16'd0);
    check("wr_en", 16'(lifo_wr_en), 16'(!o && !exp_err));
    check("rd_en", 16'(lifo_rd_en), 16'(o && !exp_err));
    if (!o && !exp_err) check("din", 16'(lifo_din), 16'(d));
    req[c] = 1'b0;
    if (exp_err) exp_rej++;
    if (!o && !exp_err) begin
      ref_stack.push_back(d);
      exp_push++;
    end
    if (o && !exp_err) begin
      sb.push_back(ref_stack.pop_back());
      exp_pop++;
      seen = '0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (rvalid != '0) begin
          seen = rvalid;
          break;
        end
      end
      check("rvalid", 16'(seen), 16'(oh));
      check("rdata", 16'(rdata), 16'(sb.pop_front()));
      last_rdata = rdata;
    end else begin
      seen = '0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        seen |= rvalid;
      end
      check("no_rvalid", 16'(seen), 16'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [NR-1:0] g;
    logic [NR-1:0] exp_g;
    logic [NR-1:0] seen;

    // Reset with both clients requesting pushes.
    req = 2'b11;
    op  = 2'b00;
    wdata = {4'h2, 4'h1};
    @(negedge clk);
    check("rst_gnt", 16'(gnt), 16'd0);
    check("rst_err", 16'(err), 16'd0);
    check("rst_rvalid", 16'(rvalid), 16'd0);
    check("rst_rdata", 16'(rdata), 16'd0);
    check("rst_wr_en", 16'(lifo_wr_en), 16'd0);
    check("rst_rd_en", 16'(lifo_rd_en), 16'd0);
    check("rst_din", 16'(lifo_din), 16'd0);
    rst = 1'b0;
    wait_gnt(g);
    check("first_gnt", 16'(g), 16'h1);
    req[0] = 1'b0;
    wait_gnt(g);
    check("second_gnt", 16'(g), 16'h2);
    req[1] = 1'b0;

    // Push 3,7,A then pop twice; client1 then pushes B which client0 pops.
    do_reset();
    txn(0, 1'b0, 4'h3, 1'b0);
    txn(0, 1'b0, 4'h7, 1'b0);
    txn(0, 1'b0, 4'hA, 1'b0);
    txn(0, 1'b1, 4'h0, 1'b0);
    txn(0, 1'b1, 4'h0, 1'b0);
    txn(1, 1'b0, 4'hB, 1'b0);
    check("rdata_hold", 16'(rdata), 16'(last_rdata));
    txn(0, 1'b1, 4'h0, 1'b0);
    check_stats();

    // Continuous requests from both clients alternate.
    do_reset();
    req = 2'b11;
    op  = 2'b00;
    exp_g = 2'b01;
    for (int n = 0; n < 6; n++) begin
      wait_gnt(g);
      check("alternate", 16'(g), 16'(exp_g));
      exp_g = ~exp_g;
    end
    req = '0;

    // Pop on empty is rejected without a strobe.
    do_reset();
    txn(1, 1'b1, 4'h0, 1'b1);
    check_stats();

    // Fill, push on full is rejected, then pop returns the old top.
    do_reset();
    txn(0, 1'b0, 4'h1, 1'b0);
    txn(1, 1'b0, 4'h2, 1'b0);
    txn(0, 1'b0, 4'h3, 1'b0);
    txn(1, 1'b0, 4'h4, 1'b0);
    txn(0, 1'b0, 4'h5, 1'b1);
    txn(1, 1'b1, 4'h0, 1'b0);
    check_stats();

    // Reset during CAPTURE aborts the pop.
    do_reset();
    txn(0, 1'b0, 4'h9, 1'b0);
    @(negedge clk);
    req[0] = 1'b1;
    op[0]  = 1'b1;
    wait_gnt(g);
    check("abort_gnt", 16'(g), 16'h1);
    req[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen |= rvalid | gnt;
      seen[0] = seen[0] | lifo_wr_en | lifo_rd_en;
    end
    check("abort_quiet", 16'(seen), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
